// File: rtl/serial_bridge.sv
// serial_bridge: far-end partner of the processor's serial IO port, bridging it to an 8N1 UART line.
// Latency: byte written at edge k drives the start bit after edge k+1; received byte visible 1 cycle after its stop sample.
// Backpressure: cpu_ready_out drops when the TX FIFO is full (further writes dropped); RX bytes dropped with sticky overrun when RX FIFO full.
//
// Ports:
//   clock, reset                  system clock, synchronous active-high reset
//   cpu_data_in/cpu_wren_in       byte from processor, pushed into TX FIFO
//   cpu_rden_in                   pop RX FIFO head
//   cpu_data_out/cpu_valid_out    RX FIFO head (show-ahead), 8'h00 when empty
//   cpu_ready_out                 TX FIFO not full
//   uart_rx_in/uart_tx_out        UART line, idle high
//   tx_busy_out                   frame in flight or TX bytes queued
//   rx_overrun_out/rx_frame_err_out  sticky receive error flags

// sb_fifo: generic show-ahead FIFO, power-of-two depth.
// Latency: push visible at head the cycle after the edge; pop advances head at the edge.
// Backpressure: push while full is dropped, pop while empty is ignored (full/empty from pre-edge state).
module sb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign head_dat = mem_q[rd_ptr_q];
   assign push_ok  = push_vld && !full;
   assign pop_ok   = pop_rdy && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset: head is never consumed while count is zero.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// serial_bridge: CPU byte interface <-> 8N1 UART with TX and RX FIFOs.
// Latency: see file header; TX frames are back-to-back while the TX FIFO holds data.
// Backpressure: cpu_ready_out = TX FIFO not full; RX side has no backpressure toward the line.
module serial_bridge #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] cpu_data_in,
   input  logic       cpu_wren_in,
   input  logic       cpu_rden_in,
   output logic [7:0] cpu_data_out,
   output logic       cpu_valid_out,
   output logic       cpu_ready_out,
   input  logic       uart_rx_in,
   output logic       uart_tx_out,
   output logic       tx_busy_out,
   output logic       rx_overrun_out,
   output logic       rx_frame_err_out
);
   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   // ---------------- TX side ----------------
   state_t        tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          tx_line_q, tx_line_d;
   logic          tx_pop;
   logic [7:0]    tx_head;
   logic          tx_full;
   logic          tx_empty;

   sb_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock    (clock),
      .reset    (reset),
      .push_vld (cpu_wren_in),
      .push_dat (cpu_data_in),
      .pop_rdy  (tx_pop),
      .head_dat (tx_head),
      .full     (tx_full),
      .empty    (tx_empty)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CW'(1);
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         ST_IDLE: begin
            tx_cnt_d = '0;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_shift_d = tx_head;
               tx_state_d = ST_START;
            end
         end
         ST_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = ST_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end
         end
         ST_STOP: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               // Chain straight into the next start bit when more bytes are queued.
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_shift_d = tx_head;
                  tx_state_d = ST_START;
               end else begin
                  tx_state_d = ST_IDLE;
               end
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase
   end

   // Line level is decoded from the next state so the registered output changes on the same edge as the FSM.
   always_comb begin
      case (tx_state_d)
         ST_START: tx_line_d = 1'b0;
         ST_DATA:  tx_line_d = tx_shift_d[0];
         default:  tx_line_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_line_q  <= tx_line_d;
      end
   end

   // ---------------- RX side ----------------
   logic          rx_sync1_q, rx_sync1_d;
   logic          rx_sync2_q, rx_sync2_d;
   state_t        rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic          overrun_q, overrun_d;
   logic          frame_err_q, frame_err_d;
   logic          rx_push;
   logic [7:0]    rx_head;
   logic          rx_full;
   logic          rx_empty;

   sb_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock    (clock),
      .reset    (reset),
      .push_vld (rx_push),
      .push_dat (rx_shift_q),
      .pop_rdy  (cpu_rden_in),
      .head_dat (rx_head),
      .full     (rx_full),
      .empty    (rx_empty)
   );

   assign rx_sync1_d = uart_rx_in;
   assign rx_sync2_d = rx_sync1_q;

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q + CW'(1);
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;
      rx_push     = 1'b0;
      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            if (!rx_sync2_q) begin
               rx_state_d = ST_START;
            end
         end
         ST_START: begin
            // Half-bit re-check rejects short low glitches and aligns later samples to mid-bit.
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = ST_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = ST_IDLE;
               if (rx_sync2_q) begin
                  rx_push = 1'b1;
                  if (rx_full) begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_sync1_q  <= 1'b1;
         rx_sync2_q  <= 1'b1;
         rx_state_q  <= ST_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_sync1_q  <= rx_sync1_d;
         rx_sync2_q  <= rx_sync2_d;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      cpu_valid_out    = !rx_empty;
      cpu_data_out     = rx_empty ? 8'h00 : rx_head;
      cpu_ready_out    = !tx_full;
      uart_tx_out      = tx_line_q;
      tx_busy_out      = (tx_state_q != ST_IDLE) || !tx_empty;
      rx_overrun_out   = overrun_q;
      rx_frame_err_out = frame_err_q;
   end
endmodule

// File: tb/tb_serial_bridge.sv
// tb_serial_bridge: directed, table-driven bench for serial_bridge at CLKS_PER_BIT=4, FIFO_DEPTH=8.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every wait on the DUT is bounded; a global watchdog ends a stuck run.
module tb_serial_bridge;
   localparam int C = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] cpu_data_in;
   logic       cpu_wren_in;
   logic       cpu_rden_in;
   logic [7:0] cpu_data_out;
   logic       cpu_valid_out;
   logic       cpu_ready_out;
   logic       uart_rx_in;
   logic       uart_tx_out;
   logic       tx_busy_out;
   logic       rx_overrun_out;
   logic       rx_frame_err_out;

   serial_bridge #(.CLKS_PER_BIT(C), .FIFO_DEPTH(8)) dut (
      .clock            (clock),
      .reset            (reset),
      .cpu_data_in      (cpu_data_in),
      .cpu_wren_in      (cpu_wren_in),
      .cpu_rden_in      (cpu_rden_in),
      .cpu_data_out     (cpu_data_out),
      .cpu_valid_out    (cpu_valid_out),
      .cpu_ready_out    (cpu_ready_out),
      .uart_rx_in       (uart_rx_in),
      .uart_tx_out      (uart_tx_out),
      .tx_busy_out      (tx_busy_out),
      .rx_overrun_out   (rx_overrun_out),
      .rx_frame_err_out (rx_frame_err_out)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] dat;
      logic [9:0] frame;   // bit i = line level during UART bit i (0 = start, 9 = stop)
   } tx_vec_t;

   typedef struct {
      logic [7:0] dat;
      logic       stop;
      logic       exp_vld;
      logic [7:0] exp_dat;
      logic       exp_ferr;
   } rx_vec_t;

   tx_vec_t tx_tab [4];
   rx_vec_t rx_tab [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      uart_rx_in = 1'b0;
      repeat (C) tick();
      for (int i = 0; i < 8; i++) begin
         uart_rx_in = b[i];
         repeat (C) tick();
      end
      uart_rx_in = stop;
      repeat (C) tick();
      uart_rx_in = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   p;
      int   f;
      int   b;
      logic exp_bit;
      logic got;
      logic saw_low;

      tx_tab[0] = '{dat: 8'hA5, frame: 10'b1_10100101_0};
      tx_tab[1] = '{dat: 8'h00, frame: 10'b1_00000000_0};
      tx_tab[2] = '{dat: 8'hFF, frame: 10'b1_11111111_0};
      tx_tab[3] = '{dat: 8'h3C, frame: 10'b1_00111100_0};

      rx_tab[0] = '{dat: 8'h3C, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'h3C, exp_ferr: 1'b0};
      rx_tab[1] = '{dat: 8'h00, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'h00, exp_ferr: 1'b0};
      rx_tab[2] = '{dat: 8'hFF, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'hFF, exp_ferr: 1'b0};
      rx_tab[3] = '{dat: 8'h5A, stop: 1'b0, exp_vld: 1'b0, exp_dat: 8'h00, exp_ferr: 1'b1};
      rx_tab[4] = '{dat: 8'hC3, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'hC3, exp_ferr: 1'b1};

      reset       = 1'b1;
      cpu_data_in = 8'h00;
      cpu_wren_in = 1'b0;
      cpu_rden_in = 1'b0;
      uart_rx_in  = 1'b1;
      repeat (3) tick();

      // Reset state
      check("rst_tx",      uart_tx_out,      1);
      check("rst_valid",   cpu_valid_out,    0);
      check("rst_ready",   cpu_ready_out,    1);
      check("rst_data",    cpu_data_out,     0);
      check("rst_busy",    tx_busy_out,      0);
      check("rst_overrun", rx_overrun_out,   0);
      check("rst_ferr",    rx_frame_err_out, 0);
      reset = 1'b0;
      repeat (2) tick();

      // Single-byte TX frames
      foreach (tx_tab[v]) begin
         cpu_data_in = tx_tab[v].dat;
         cpu_wren_in = 1'b1;
         tick();
         cpu_wren_in = 1'b0;
         check($sformatf("tx%0d_line_at_k", v), uart_tx_out, 1);
         for (int c = 0; c < 10 * C; c++) begin
            tick();
            check($sformatf("tx%0d_cyc%0d", v, c), uart_tx_out, tx_tab[v].frame[c / C]);
         end
         tick();
         check($sformatf("tx%0d_busy_end", v), tx_busy_out, 0);
         check($sformatf("tx%0d_line_end", v), uart_tx_out, 1);
         repeat (3) tick();
      end

      // One-cycle low glitch on the RX line
      uart_rx_in = 1'b0;
      tick();
      uart_rx_in = 1'b1;
      repeat (20) tick();
      check("glitch_valid", cpu_valid_out,    0);
      check("glitch_ferr",  rx_frame_err_out, 0);

      // RX frames
      foreach (rx_tab[v]) begin
         send_rx(rx_tab[v].dat, rx_tab[v].stop);
         got = 1'b0;
         for (int w = 0; w < 12 && !got; w++) begin
            if (cpu_valid_out) got = 1'b1;
            else tick();
         end
         check($sformatf("rx%0d_valid", v), cpu_valid_out,    rx_tab[v].exp_vld);
         check($sformatf("rx%0d_data",  v), cpu_data_out,     rx_tab[v].exp_dat);
         check($sformatf("rx%0d_ferr",  v), rx_frame_err_out, rx_tab[v].exp_ferr);
         if (got) begin
            cpu_rden_in = 1'b1;
            tick();
            cpu_rden_in = 1'b0;
            check($sformatf("rx%0d_valid_after_pop", v), cpu_valid_out, 0);
            check($sformatf("rx%0d_data_after_pop",  v), cpu_data_out,  0);
         end
         repeat (4) tick();
      end

      // Ten consecutive writes, TX FIFO overflows on the tenth
      cpu_data_in = 8'h00;
      cpu_wren_in = 1'b1;
      for (int c = 0; c < 380; c++) begin
         tick();
         if (c <= 9) check($sformatf("b2b_ready_%0d", c), cpu_ready_out, (c < 8) ? 1 : 0);
         if (c < 9) cpu_data_in = 8'(c + 1);
         else       cpu_wren_in = 1'b0;
         if (c >= 1) begin
            p = c - 1;
            f = p / (10 * C);
            b = (p % (10 * C)) / C;
            if (f >= 9)      exp_bit = 1'b1;
            else if (b == 0) exp_bit = 1'b0;
            else if (b == 9) exp_bit = 1'b1;
            else             exp_bit = ((f >> (b - 1)) & 1) != 0;
            check($sformatf("b2b_line_cyc%0d", c), uart_tx_out, exp_bit);
         end
      end
      check("b2b_busy_end", tx_busy_out, 0);

      // RX overrun: nine frames, no reads
      for (int i = 1; i <= 9; i++) begin
         send_rx(8'(i), 1'b1);
         repeat (4) tick();
         if (i == 8) check("ovr_flag_before", rx_overrun_out, 0);
      end
      check("ovr_flag_after", rx_overrun_out, 1);
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("ovr_valid_%0d", i), cpu_valid_out, 1);
         check($sformatf("ovr_data_%0d",  i), cpu_data_out,  i);
         cpu_rden_in = 1'b1;
         tick();
         cpu_rden_in = 1'b0;
      end
      check("ovr_empty_valid", cpu_valid_out, 0);
      check("ovr_empty_data",  cpu_data_out,  0);

      // Pop while empty is ignored; a following frame still arrives intact
      cpu_rden_in = 1'b1;
      tick();
      cpu_rden_in = 1'b0;
      send_rx(8'h7E, 1'b1);
      repeat (3) tick();
      check("empty_pop_valid", cpu_valid_out, 1);
      check("empty_pop_data",  cpu_data_out,  8'h7E);

      // Reset in the middle of a TX frame with three bytes queued
      for (int i = 0; i < 4; i++) begin
         cpu_data_in = 8'(8'h11 * (i + 1));
         cpu_wren_in = 1'b1;
         tick();
      end
      cpu_wren_in = 1'b0;
      repeat (15) tick();
      check("midrst_busy_before", tx_busy_out, 1);
      reset = 1'b1;
      tick();
      check("midrst_tx",      uart_tx_out,      1);
      check("midrst_ready",   cpu_ready_out,    1);
      check("midrst_busy",    tx_busy_out,      0);
      check("midrst_valid",   cpu_valid_out,    0);
      check("midrst_data",    cpu_data_out,     0);
      check("midrst_overrun", rx_overrun_out,   0);
      check("midrst_ferr",    rx_frame_err_out, 0);
      reset = 1'b0;
      saw_low = 1'b0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (!uart_tx_out) saw_low = 1'b1;
      end
      check("midrst_no_more_frames", saw_low,     0);
      check("midrst_busy_after",     tx_busy_out, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
